// File: rtl/divider_scheduler_pkg.sv
// Shared types and helpers for the round-robin divider scheduler.
// Holds the FSM state type, the default watchdog limit and a width helper.
package divider_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 16;

    // Bits needed to hold 0..value-1; never less than one.
    function automatic int unsigned clog2w(input int unsigned value);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/divider_scheduler_if.sv
// Requester and divider side signals of the scheduler, bundled with views
// for the scheduler (slave) and for the clients plus divider (master).
interface divider_scheduler_if #(
    parameter int unsigned OPERAND_W = 8,
    parameter int unsigned NUM_REQ   = 4
);
    logic [NUM_REQ-1:0]           ReqValid;
    logic [NUM_REQ*OPERAND_W-1:0] ReqDividend;
    logic [NUM_REQ*OPERAND_W-1:0] ReqDivisor;
    logic [NUM_REQ-1:0]           ReqReady;
    logic [NUM_REQ-1:0]           RespValid;
    logic [OPERAND_W-1:0]         RespQuotient;
    logic [OPERAND_W-1:0]         RespRemainder;
    logic                         RespError;
    logic                         Busy;
    logic                         DivReq;
    logic [OPERAND_W-1:0]         DivOperand1;
    logic [OPERAND_W-1:0]         DivOperand2;
    logic [OPERAND_W-1:0]         DivQuotient;
    logic [OPERAND_W-1:0]         DivRemainder;
    logic                         DivDone;

    modport slave (
        input  ReqValid, ReqDividend, ReqDivisor,
        input  DivQuotient, DivRemainder, DivDone,
        output ReqReady, RespValid, RespQuotient, RespRemainder, RespError,
        output Busy, DivReq, DivOperand1, DivOperand2
    );

    modport master (
        output ReqValid, ReqDividend, ReqDivisor,
        output DivQuotient, DivRemainder, DivDone,
        input  ReqReady, RespValid, RespQuotient, RespRemainder, RespError,
        input  Busy, DivReq, DivOperand1, DivOperand2
    );

endinterface

// File: rtl/divider_scheduler_rr_arbiter.sv
// Combinational round-robin picker: the search starts just after the last
// served requester and wraps, returning a one-hot grant and its index.
module rr_arbiter
    import divider_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = clog2w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    always_comb begin
        logic [IDX_W-1:0] w_cand;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((32'(i_last) + k) % NUM_REQ);
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/divider_scheduler.sv
// Shares one divider between NUM_REQ requesters: round-robin accept, divider
// handshake sequencing, local divide-by-zero results and a WAIT watchdog.
module divider_scheduler
    import divider_sched_pkg::*;
#(
    parameter int unsigned OPERAND_W = 8,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic               Clock,
    input  logic               nReset,
    divider_scheduler_if.slave bus
);

    localparam int unsigned      IDX_W     = clog2w(NUM_REQ);
    localparam int unsigned      TMR_W     = clog2w(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

    sched_state_t         r_state;
    logic [IDX_W-1:0]     r_last;
    logic [IDX_W-1:0]     r_idx;
    logic [OPERAND_W-1:0] r_dividend;
    logic [OPERAND_W-1:0] r_divisor;
    logic [OPERAND_W-1:0] r_quot;
    logic [OPERAND_W-1:0] r_rem;
    logic                 r_err;
    logic [TMR_W-1:0]     r_timer;

    logic [NUM_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_any;
    logic [OPERAND_W-1:0] w_dividend;
    logic [OPERAND_W-1:0] w_divisor;
    logic [NUM_REQ-1:0]   w_resp_vec;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req   (bus.ReqValid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    always_comb begin
        w_dividend = bus.ReqDividend[32'(w_idx) * OPERAND_W +: OPERAND_W];
        w_divisor  = bus.ReqDivisor[32'(w_idx) * OPERAND_W +: OPERAND_W];
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state    <= IDLE;
            r_last     <= LAST_INIT;
            r_idx      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_err      <= 1'b0;
            r_timer    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_idx      <= w_idx;
                        r_dividend <= w_dividend;
                        r_divisor  <= w_divisor;
                        if (w_divisor == '0) begin
                            r_quot  <= '1;
                            r_rem   <= w_dividend;
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end else begin
                            r_state <= START;
                        end
                    end
                end
                START: begin
                    r_timer <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    // A Done on the last watchdog cycle still delivers the result.
                    if (bus.DivDone) begin
                        r_quot  <= bus.DivQuotient;
                        r_rem   <= bus.DivRemainder;
                        r_err   <= 1'b0;
                        r_state <= RESP;
                    end else if (r_timer == TMR_LAST) begin
                        r_quot  <= '0;
                        r_rem   <= '0;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_last  <= r_idx;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_resp_vec = '0;
        if (r_state == RESP) begin
            w_resp_vec[r_idx] = 1'b1;
        end
    end

    // The accept strobe is combinational, so it is also masked while reset is held.
    always_comb begin
        bus.ReqReady      = (r_state == IDLE && nReset) ? w_grant : '0;
        bus.RespValid     = w_resp_vec;
        bus.RespQuotient  = (r_state == RESP) ? r_quot : '0;
        bus.RespRemainder = (r_state == RESP) ? r_rem : '0;
        bus.RespError     = (r_state == RESP) ? r_err : 1'b0;
        bus.Busy          = (r_state != IDLE);
        bus.DivReq        = (r_state == START);
        bus.DivOperand1   = r_dividend;
        bus.DivOperand2   = r_divisor;
    end

endmodule

// File: doc/divider_scheduler.md
# divider_scheduler

Shares one `divider` instance between `NUM_REQ` requesters using round-robin arbitration. It accepts one operand pair at a time, sequences the divider's `Req`/`Done` handshake, and returns the quotient and remainder to the granted requester. Divide-by-zero requests are resolved locally without starting the divider. A stuck divider is recovered by a watchdog. The block sits between the client logic and the `divider` top level; both are in the same clock/reset domain.

## Interface
- `OPERAND_W`, 8, operand/result width.
- `NUM_REQ`, 4, number of requesters (2..8).
- `TIMEOUT`, 16, maximum cycles spent in WAIT before abort (must exceed divider latency of 10).

- `Clock`  in  1  sole clock, rising edge.
- `nReset`  in  1  asynchronous, active-low reset. The same net resets the divider.
- `ReqValid`  in  NUM_REQ  per-requester request. Held high with operands stable until accepted.
- `ReqDividend`  in  NUM_REQ*OPERAND_W  flat; slice i belongs to requester i.
- `ReqDivisor`  in  NUM_REQ*OPERAND_W  flat; slice i belongs to requester i.
- `ReqReady`  out  NUM_REQ  one-hot accept strobe.
- `RespValid`  out  NUM_REQ  one-hot, single-cycle result strobe.
- `RespQuotient`  out  OPERAND_W  result, valid while any `RespValid` is high.
- `RespRemainder`  out  OPERAND_W  result, valid while any `RespValid` is high.
- `RespError`  out  1  qualifies the response: divide-by-zero or timeout.
- `Busy`  out  1  high in every state except IDLE.
- `DivReq`  out  1  to divider `Req`.
- `DivOperand1`  out  OPERAND_W  to divider `Operand1`.
- `DivOperand2`  out  OPERAND_W  to divider `Operand2`.
- `DivQuotient`  in  OPERAND_W  from divider.
- `DivRemainder`  in  OPERAND_W  from divider.
- `DivDone`  in  1  from divider.

## Operation
States: IDLE, START, WAIT, RESP.

- **IDLE**
  - If any `ReqValid` is high, select winner w. Search starts at `(last+1) mod NUM_REQ`, where `last` is the last requester served.
  - `ReqReady[w]` is asserted combinationally in this same cycle.
  - Register the dividend, divisor and w.
  - If the divisor is 0: load quotient = all ones, remainder = dividend, error = 1, then go to RESP.
  - Otherwise go to START.
- **START**
  - `DivReq` = 1 for exactly this cycle.
  - Clear the watchdog timer.
  - Go to WAIT.
- **WAIT**
  - `DivReq` = 0. `DivOperand1/2` stay held from the registered operands; they are stable from START through WAIT.
  - Timer increments each cycle.
  - If `DivDone` = 1: capture `DivQuotient`/`DivRemainder` with error = 0, go to RESP.
  - Otherwise, if the timer reaches `TIMEOUT-1`: load quotient 0, remainder 0, error = 1, go to RESP.
  - If `DivDone` and timeout occur in the same cycle, `DivDone` wins.
- **RESP**
  - `RespValid[w]` = 1 for one cycle; result registers drive `RespQuotient`, `RespRemainder` and `RespError`.
  - Set `last` = w.
  - Go to IDLE.
- `DivDone` is ignored outside WAIT.
- `ReqValid` dropping before accept is legal; that requester is simply not granted.
- Responses and accepts are never simultaneous. At most one request is outstanding.
- Results are zero whenever `RespValid` is low.

## Timing
- **Reset** (asynchronous, any state):
  - State goes to IDLE; `last` goes to `NUM_REQ-1`, so requester 0 has first priority.
  - All outputs go to 0, including `DivReq` and `DivOperand*`.
  - An in-flight request is dropped with no response. The requester must re-request.
- **Latency**, with accept at cycle 0:
  - `DivReq` at cycle 1.
  - With a 10-cycle divider, `DivDone` is seen at cycle 11 and `RespValid` at cycle 12.
  - Divide-by-zero: `RespValid` at cycle 1.
  - Timeout: `RespValid` at cycle `TIMEOUT+2`.
- **Throughput:** the next accept can occur in the cycle after RESP, so a normal transaction costs 13 cycles per request.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,2,3,0,… Worst-case wait is `NUM_REQ-1` transactions.

## Structure
- Package `divider_sched_pkg` holds:
  - `sched_state_t` enum {IDLE, START, WAIT, RESP};
  - the default `TIMEOUT` constant;
  - a `CLOG2`-style width function for the timer and index.
- Sub-module `rr_arbiter` (parameter `NUM_REQ`) is purely combinational.
  - Inputs: request vector and `last` index.
  - Outputs: one-hot grant and binary index.
- The FSM, timer, operand/result registers and `last` pointer live in `divider_scheduler`.

## Test plan
- **Single request:** requester 2 issues 200/7 → `ReqReady[2]` at cycle 0, `DivReq` at cycle 1; `RespValid[2]` with Q=28, R=4, Error=0 at cycle 12.
- **Contention:** requesters 0, 1 and 3 are all valid after reset → served in order 0, 1, 3, then 0 again if still valid. No requester is granted twice while another waits.
- **Divide by zero:** requester 1 issues 100/0 → `RespValid[1]` at cycle 1 with Q=0xFF, R=100, Error=1; `DivReq` never asserts.
- **Timeout:** divider stub never raises `DivDone` → `RespError`=1, Q=0, R=0 at cycle `TIMEOUT+2`; the next request proceeds normally.
- **Reset mid-WAIT:** `nReset` low at cycle 5 → all outputs are 0 immediately. After release, the pending requester 0 is re-granted first and gets the correct result.
- **Done/timeout collision and stray Done:** `DivDone` coincides with the final timeout cycle → divider result is returned with Error=0. `DivDone` pulsed in IDLE → no response.
